aes_round_ctrl: RTL

//  Sequencer for the iterative AES-128 datapath behind interfaceAES.

---
 rtl/aes_pkg.sv | 34 +++
 rtl/aes_round_ctrl.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/aes_pkg.sv
// Shared types and constants for the AES-128 round sequencer.
// Holds the controller state encoding and the key-expansion RCON table.
package aes_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ROUND,
        FINAL,
        DONE
    } aes_ctrl_state_t;

    localparam int AES_NR = 10;

    // Round constant used by the key schedule for round 1..10, zero elsewhere
    function automatic logic [7:0] aes_rcon(input logic [3:0] idx);
        logic [7:0] rc;
        case (idx)
            4'd1:    rc = 8'h01;
            4'd2:    rc = 8'h02;
            4'd3:    rc = 8'h04;
            4'd4:    rc = 8'h08;
            4'd5:    rc = 8'h10;
            4'd6:    rc = 8'h20;
            4'd7:    rc = 8'h40;
            4'd8:    rc = 8'h80;
            4'd9:    rc = 8'h1b;
            4'd10:   rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

endpackage

// File: rtl/aes_round_ctrl.sv
// Round sequencer for the iterative AES-128 datapath: load, NR rounds, done.
// Optional macro AES_IRQ_EN adds a sticky completion flag on irq (cleared by irq_clr).
module aes_round_ctrl
    import aes_pkg::*;
#(
    parameter int NR         = AES_NR,
    parameter int RND_CYCLES = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       abort,
    output logic       busy,
    output logic       done,
    output logic       load_state,
    output logic       round_en,
    output logic       key_exp_en,
    output logic       last_round,
    output logic       result_we,
    output logic [3:0] round_idx,
    output logic [7:0] rcon,
    output logic       irq,
    input  logic       irq_clr
);

    localparam int              CW       = (RND_CYCLES > 1) ? $clog2(RND_CYCLES) : 1;
    localparam logic [CW-1:0]   CYC_LAST = CW'(RND_CYCLES - 1);
    localparam logic [3:0]      IDX_PRE  = 4'(NR - 1);

    aes_ctrl_state_t r_state;
    aes_ctrl_state_t w_next;
    logic [CW-1:0]   r_cyc;
    logic [CW-1:0]   w_cyc_nxt;
    logic [3:0]      r_idx;
    logic [3:0]      w_idx_nxt;
    logic            w_rnd_end;
    logic            w_active;

    assign w_rnd_end = (r_cyc == CYC_LAST);
    assign w_active  = (r_state == LOAD) || (r_state == ROUND) || (r_state == FINAL);
    assign round_idx = r_idx;

    // State, sub-round cycle counter and round index registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
            r_cyc   <= '0;
            r_idx   <= '0;
        end else begin
            r_state <= w_next;
            r_cyc   <= w_cyc_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    // Next-state logic and per-round datapath strobes
    always_comb begin
        w_next     = r_state;
        w_cyc_nxt  = r_cyc;
        w_idx_nxt  = r_idx;
        busy       = 1'b0;
        done       = 1'b0;
        load_state = 1'b0;
        round_en   = 1'b0;
        key_exp_en = 1'b0;
        last_round = 1'b0;
        result_we  = 1'b0;
        rcon       = 8'h00;
        unique case (r_state)
            IDLE: begin
                if (start && !abort) w_next = LOAD;
            end
            LOAD: begin
                busy       = 1'b1;
                load_state = 1'b1;
                w_next     = (NR == 1) ? FINAL : ROUND;
                w_idx_nxt  = 4'd1;
                w_cyc_nxt  = '0;
            end
            ROUND: begin
                busy = 1'b1;
                rcon = aes_rcon(r_idx);
                if (w_rnd_end) begin
                    round_en   = 1'b1;
                    key_exp_en = 1'b1;
                    w_cyc_nxt  = '0;
                    w_idx_nxt  = r_idx + 4'd1;
                    if (r_idx == IDX_PRE) w_next = FINAL;
                end else begin
                    w_cyc_nxt = r_cyc + CW'(1);
                end
            end
            FINAL: begin
                busy       = 1'b1;
                last_round = 1'b1;
                rcon       = aes_rcon(r_idx);
                if (w_rnd_end) begin
                    round_en   = 1'b1;
                    key_exp_en = 1'b1;
                    result_we  = 1'b1;
                    w_cyc_nxt  = '0;
                    w_idx_nxt  = 4'd0;
                    w_next     = DONE;
                end else begin
                    w_cyc_nxt = r_cyc + CW'(1);
                end
            end
            DONE: begin
                done   = 1'b1;
                w_next = IDLE;
            end
            default: begin
                w_next    = IDLE;
                w_cyc_nxt = '0;
                w_idx_nxt = '0;
            end
        endcase
        // An abort discards the operation: no further writes reach the datapath
        if (abort && w_active) begin
            w_next     = IDLE;
            w_cyc_nxt  = '0;
            w_idx_nxt  = '0;
            load_state = 1'b0;
            round_en   = 1'b0;
            key_exp_en = 1'b0;
            result_we  = 1'b0;
        end
    end

`ifdef AES_IRQ_EN
    logic r_irq;

    // Sticky completion flag; a new completion beats a simultaneous clear
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_irq <= 1'b0;
        end else if (r_state == DONE) begin
            r_irq <= 1'b1;
        end else if (irq_clr) begin
            r_irq <= 1'b0;
        end
    end

    assign irq = r_irq || (r_state == DONE);
`else
    logic w_unused_irq_clr;
    assign w_unused_irq_clr = irq_clr;
    assign irq              = 1'b0;
`endif

endmodule
